mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single DATA_MEMORY port between two requesters: m0 (CPU load/store path) and m1 (debug/program loader or DMA).
- One access per cycle. Fixed priority to m0 when idle, with a burst limit so neither requester is starved.
- Returns read data after a fixed memory latency, tagged back to the requester that issued the read.
- Generates a stall for the CPU while its request is not granted.

Parameters:
- RD_LATENCY, 1, cycles from a granted read to valid mem_rd; legal range 1..4.
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requester is waiting; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  CPU access request; held with its fields stable until granted
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address (DATA_BUS)
- m0_wdata  in  32  write data (DATA_BUS)
- m0_bsel  in  byte_format  byte/half/word select
- m0_gnt  out  1  access accepted this cycle
- m0_rvalid  out  1  read data for m0 present on m0_rdata
- m0_rdata  out  32  read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_bsel, m1_gnt, m1_rvalid, m1_rdata: same as the m0 ports, for requester m1
- mem_a  out  32  to DATA_MEMORY A
- mem_we  out  1  to DATA_MEMORY WE
- mem_wd  out  32  to DATA_MEMORY WD
- mem_bsel  out  byte_format  to DATA_MEMORY ByteSelect
- mem_rd  in  32  from DATA_MEMORY RD
- cpu_stall  out  1  m0_req & ~m0_gnt, combinational

Behaviour:
- Reset state: owner = IDLE, burst_cnt = 0, read pipe empty. After reset: all gnt/rvalid = 0, mem_we = 0, cpu_stall = m0_req.
- Owner FSM states: IDLE, OWN_M0, OWN_M1. burst_cnt is a counter wide enough for MAX_BURST.
- Grant decision is combinational from the current state and the req inputs. At most one gnt per cycle. A transfer happens when req & gnt.
- No req: no grant; next owner = IDLE, burst_cnt = 0.
- Exactly one req: grant that requester.
- Both req, owner IDLE: grant m0.
- Both req, owner OWN_x, burst_cnt < MAX_BURST: grant x.
- Both req, owner OWN_x, burst_cnt == MAX_BURST: grant the other requester.
- On a grant to requester g:
  - If g differs from owner, or the other req is low: owner ← OWN_g, burst_cnt ← 1.
  - Otherwise: burst_cnt ← burst_cnt + 1, saturating at MAX_BURST.
- Resulting pattern with both requesters held high and MAX_BURST = 4: m0×4, m1×4, m0×4, ...
- Memory mux:
  - mem_a/mem_wd/mem_bsel come from the granted requester; mem_we = granted requester's we.
  - With no grant: the m0 fields are driven and mem_we = 0.
- Writes: complete in the grant cycle; no rvalid is generated.
- Reads:
  - A granted read pushes {valid, id} into a RD_LATENCY-deep shift pipe.
  - When the pipe output is valid: the matching mx_rvalid = 1 for exactly one cycle, in the cycle mem_rd is valid (grant cycle + RD_LATENCY).
  - m0_rdata = m1_rdata = mem_rd at all times; rvalid qualifies it.
- Back-to-back reads: one issue per cycle is accepted; returns come in order, one per cycle.
- Simultaneous read return and new grant: both happen in the same cycle, independently.
- Reset mid-operation: the pipe is flushed; in-flight reads never produce rvalid. Requesters must re-issue them.
- Requests are not latched. If a req is dropped before its grant, nothing is recorded.

Optional Feature:
- Macro: ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 32-bit: a saturating count of cycles with cpu_stall = 1.
  - Adds output m1_wait_cnt, 32-bit: the same count for m1_req & ~m1_gnt.
  - Both counters clear on rst and hold at 32'hFFFF_FFFF.
- When undefined: neither port exists, and arbitration behaviour is identical.

Decomposition:
- types_pkg additions:
  - enum arb_owner_e {ARB_IDLE, ARB_M0, ARB_M1}.
  - Typedef arb_id_t, 1 bit, identifying the requester.
- DATA_BUS and byte_format are reused from types_pkg.
- One sub-module: arb_rd_pipe.
  - Parameter RD_LATENCY.
  - Inputs: push, id.
  - Outputs: valid, id.
  - Synchronous flush on rst.
- The FSM, burst counter and mux stay in mem_arbiter.

Test Plan:
- Reset, then m0 reads 0x100 (memory holds 0xDEADBEEF), RD_LATENCY = 1 -> m0_gnt in cycle 0, m0_rvalid = 1 with rdata 0xDEADBEEF in cycle 1, m1_rvalid stays 0.
- m0 and m1 both request continuously, MAX_BURST = 4 -> grant pattern m0,m0,m0,m0,m1,m1,m1,m1,m0; cpu_stall high only during the m1 cycles.
- m1 writes 0x12345678 to 0x40 while m0 is idle, then m0 reads 0x40 -> mem_we = 1 only in m1's grant cycle; m0 reads back 0x12345678.
- RD_LATENCY = 3, alternating m0/m1 reads back-to-back -> rvalid pulses alternate m0/m1 starting 3 cycles after the first grant, each carrying the correct data.
- rst asserted one cycle after an m1 read grant -> no m1_rvalid afterwards; owner IDLE; the next contended cycle grants m0.
- With ARB_STALL_CNT_EN defined, m0 stalled for 5 cycles -> stall_cnt = 5; after rst, stall_cnt = 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: bus width, byte-select encoding,
// arbitration owner states and the requester id carried through the read pipe.
package mem_arbiter_pkg;

    localparam int DATA_BUS = 32;

    typedef enum logic [1:0] {
        BSEL_BYTE = 2'd0,
        BSEL_HALF = 2'd1,
        BSEL_WORD = 2'd2
    } byte_format;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_owner_e;

    typedef logic arb_id_t;

    localparam arb_id_t ID_M0 = 1'b0;
    localparam arb_id_t ID_M1 = 1'b1;

endpackage

// File: rtl/arb_rd_pipe.sv
// Read-return tracker: a RD_LATENCY-deep shift pipe of {valid, id} so a read
// granted in cycle N pops out in cycle N + RD_LATENCY, when memory data is valid.
module arb_rd_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  arb_id_t push_id,
    output logic    valid,
    output arb_id_t valid_id
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] id_q;

    // Shift every stage by one each cycle; reset drops all in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q[0] <= push;
            id_q[0]  <= push_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign valid    = vld_q[RD_LATENCY-1];
    assign valid_id = id_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single data-memory port. m0 (CPU) wins when
// the port is idle; a burst limit hands the port over after MAX_BURST
// consecutive grants while the other side waits. Reads are tagged and
// returned RD_LATENCY cycles after their grant.
// Optional build macro ARB_STALL_CNT_EN adds saturating wait counters
// (stall_cnt for m0, m1_wait_cnt for m1).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [DATA_BUS-1:0] m0_addr,
    input  logic [DATA_BUS-1:0] m0_wdata,
    input  byte_format          m0_bsel,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_BUS-1:0] m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [DATA_BUS-1:0] m1_addr,
    input  logic [DATA_BUS-1:0] m1_wdata,
    input  byte_format          m1_bsel,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_BUS-1:0] m1_rdata,
    output logic [DATA_BUS-1:0] mem_a,
    output logic                mem_we,
    output logic [DATA_BUS-1:0] mem_wd,
    output byte_format          mem_bsel,
    input  logic [DATA_BUS-1:0] mem_rd,
    output logic                cpu_stall
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         m1_wait_cnt
`endif
);

    localparam int CW = $clog2(MAX_BURST + 1);
    typedef logic [CW-1:0] burst_t;
    localparam burst_t BURST_MAX = burst_t'(MAX_BURST);

    arb_owner_e owner_q, owner_d;
    burst_t     burst_q, burst_d;

    logic    pipe_valid;
    arb_id_t pipe_id;
    logic    rd_push;
    arb_id_t rd_push_id;

    // Owner and burst counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= ARB_IDLE;
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    // Grant decision and owner/burst next state; no grants while in reset.
    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        if (!rst) begin
            if (m0_req && !m1_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req && !m0_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
                case (owner_q)
                    ARB_M0: begin
                        if (burst_q < BURST_MAX) m0_gnt = 1'b1;
                        else                     m1_gnt = 1'b1;
                    end
                    ARB_M1: begin
                        if (burst_q < BURST_MAX) m1_gnt = 1'b1;
                        else                     m0_gnt = 1'b1;
                    end
                    default: m0_gnt = 1'b1;
                endcase
            end

            // A new owner, or an uncontested grant, restarts the burst count.
            if (m0_gnt) begin
                if (owner_q != ARB_M0 || !m1_req) begin
                    owner_d = ARB_M0;
                    burst_d = burst_t'(1);
                end else if (burst_q < BURST_MAX) begin
                    burst_d = burst_q + burst_t'(1);
                end
            end
            if (m1_gnt) begin
                if (owner_q != ARB_M1 || !m0_req) begin
                    owner_d = ARB_M1;
                    burst_d = burst_t'(1);
                end else if (burst_q < BURST_MAX) begin
                    burst_d = burst_q + burst_t'(1);
                end
            end

            if (!m0_req && !m1_req) begin
                owner_d = ARB_IDLE;
                burst_d = '0;
            end
        end
    end

    // Memory port mux: m0 fields are parked on the bus when nobody is granted.
    always_comb begin
        mem_a    = m1_gnt ? m1_addr  : m0_addr;
        mem_wd   = m1_gnt ? m1_wdata : m0_wdata;
        mem_bsel = m1_gnt ? m1_bsel  : m0_bsel;
        mem_we   = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    end

    assign rd_push    = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
    assign rd_push_id = m1_gnt ? ID_M1 : ID_M0;

    arb_rd_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_push),
        .push_id  (rd_push_id),
        .valid    (pipe_valid),
        .valid_id (pipe_id)
    );

    assign m0_rvalid = pipe_valid & ~rst & (pipe_id == ID_M0);
    assign m1_rvalid = pipe_valid & ~rst & (pipe_id == ID_M1);
    assign m0_rdata  = mem_rd;
    assign m1_rdata  = mem_rd;
    assign cpu_stall = m0_req & ~m0_gnt;

`ifdef ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] m1_wait_cnt_q;

    // Saturating counts of cycles each requester spent waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            m1_wait_cnt_q <= '0;
        end else begin
            if (cpu_stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (m1_req && !m1_gnt && m1_wait_cnt_q != 32'hFFFF_FFFF)
                m1_wait_cnt_q <= m1_wait_cnt_q + 32'd1;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign m1_wait_cnt = m1_wait_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a run-length/queue reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int RD_LAT = 3;
    localparam int MAXB   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    byte_format  m0_bsel, m1_bsel;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;
    byte_format  mem_bsel;
    logic        cpu_stall;
`ifdef ARB_STALL_CNT_EN
    logic [31:0] stall_cnt, m1_wait_cnt;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.RD_LATENCY(RD_LAT), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_bsel(m0_bsel), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_bsel(m1_bsel), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_bsel(mem_bsel),
        .mem_rd(mem_rd), .cpu_stall(cpu_stall)
`ifdef ARB_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .m1_wait_cnt(m1_wait_cnt)
`endif
    );

    // Word-wide memory device, 256 words, read data RD_LAT cycles after address.
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [RD_LAT];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 64) ? 32'hDEAD_BEEF : (32'(i) * 32'h9E37_79B1);
        end else if (mem_we) begin
            mem[mem_a[9:2]] <= mem_wd;
        end
        rd_pipe[0] <= mem[mem_a[9:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd = rd_pipe[RD_LAT-1];

    // Reference model state.
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      run_owner;   // -1 none, 0 = m0, 1 = m1
    int      run_len;
    int      cyc;
    int      n_vec, n_err;
    bit      g0_last, g1_last;
    int      exp_stall, exp_m1w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic new_req(output logic req, output logic we, output logic [31:0] addr,
                           output logic [31:0] wd, output byte_format bs, input int pct);
        req  = ($urandom_range(0, 99) < pct);
        we   = ($urandom_range(0, 2) == 0);
        addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        wd   = $urandom;
        bs   = byte_format'($urandom_range(0, 2));
    endtask

    // Evaluate one cycle: predict, compare at negedge, advance model, move to next cycle.
    task automatic step();
        bit eg0, eg1, erv0, erv1, ewe;
        logic [31:0] erd;
        @(negedge clk);
        eg0 = 0; eg1 = 0;
        if (!rst) begin
            if (m0_req && !m1_req)      eg0 = 1;
            else if (m1_req && !m0_req) eg1 = 1;
            else if (m0_req && m1_req) begin
                if (run_owner < 0)        eg0 = 1;
                else if (run_len < MAXB)  begin if (run_owner == 0) eg0 = 1; else eg1 = 1; end
                else                      begin if (run_owner == 0) eg1 = 1; else eg0 = 1; end
            end
        end
        erv0 = 0; erv1 = 0; erd = '0;
        if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].id) erv1 = 1; else erv0 = 1;
            erd = exp_q[0].data;
        end
        ewe = (eg0 && m0_we) || (eg1 && m1_we);

        chk("m0_gnt", m0_gnt, eg0);
        chk("m1_gnt", m1_gnt, eg1);
        chk("cpu_stall", cpu_stall, m0_req & ~eg0);
        chk("mem_we", mem_we, ewe);
        if (eg1) begin
            chk("mem_a_m1", mem_a, m1_addr);
            chk("mem_bsel_m1", mem_bsel, m1_bsel);
            if (m1_we) chk("mem_wd_m1", mem_wd, m1_wdata);
        end else begin
            chk("mem_a_m0", mem_a, m0_addr);
            chk("mem_bsel_m0", mem_bsel, m0_bsel);
            if (eg0 && m0_we) chk("mem_wd_m0", mem_wd, m0_wdata);
        end
        chk("m0_rvalid", m0_rvalid, erv0);
        chk("m1_rvalid", m1_rvalid, erv1);
        if (erv0) chk("m0_rdata", m0_rdata, erd);
        if (erv1) chk("m1_rdata", m1_rdata, erd);
`ifdef ARB_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(exp_stall));
        chk("m1_wait_cnt", m1_wait_cnt, 32'(exp_m1w));
`endif

        if (rst) begin
            exp_q.delete();
            run_owner = -1;
            run_len   = 0;
            exp_stall = 0;
            exp_m1w   = 0;
        end else begin
            if (erv0 || erv1) void'(exp_q.pop_front());
            if (eg0 && !m0_we) exp_q.push_back('{cyc + RD_LAT, 1'b0, mem[m0_addr[9:2]]});
            if (eg1 && !m1_we) exp_q.push_back('{cyc + RD_LAT, 1'b1, mem[m1_addr[9:2]]});
            if (!m0_req && !m1_req) begin
                run_owner = -1; run_len = 0;
            end else if (eg0) begin
                if (run_owner != 0 || !m1_req) begin run_owner = 0; run_len = 1; end
                else if (run_len < MAXB) run_len++;
            end else if (eg1) begin
                if (run_owner != 1 || !m0_req) begin run_owner = 1; run_len = 1; end
                else if (run_len < MAXB) run_len++;
            end
            if (m0_req && !eg0) exp_stall++;
            if (m1_req && !eg1) exp_m1w++;
        end
        g0_last = eg0;
        g1_last = eg1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_flush();
        m0_req = 0;
        m1_req = 0;
        repeat (RD_LAT + 1) step();
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        run_owner = -1; run_len = 0;
        exp_stall = 0; exp_m1w = 0;
        g0_last = 0; g1_last = 0;
        rst = 1; mem_init = 1;
        m0_req = 1; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_bsel = BSEL_WORD;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_bsel = BSEL_WORD;
        @(posedge clk);
        #1;
        mem_init = 0;

        // Reset: no grants, cpu_stall follows m0_req.
        repeat (2) step();
        rst = 0;

        // m0 single read of preloaded word.
        m0_req = 1; m0_we = 0; m0_addr = 32'h100;
        step();
        idle_flush();

        // m1 write then m0 read-back of the same word.
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678;
        step();
        m1_req = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        step();
        idle_flush();

        // Both held high: burst-limited alternation.
        m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_bsel = BSEL_HALF;
        m1_req = 1; m1_we = 0; m1_addr = 32'h40;  m1_bsel = BSEL_BYTE;
        repeat (12) step();
        idle_flush();

        // Alternating single-requester reads back to back.
        for (int i = 0; i < 6; i++) begin
            m0_req = (i % 2 == 0); m1_req = (i % 2 != 0);
            m0_addr = {22'd0, 8'(i * 3), 2'b00};
            m1_addr = {22'd0, 8'(i * 5 + 1), 2'b00};
            step();
        end
        idle_flush();

        // Reset one cycle after an m1 read grant; then contention goes to m0.
        m1_req = 1; m1_we = 0; m1_addr = 32'h44;
        step();
        rst = 1; m0_req = 1; m1_req = 1;
        step();
        rst = 0;
        step();
        idle_flush();

        // Randomized traffic with occasional resets.
        repeat (800) begin
            if (!(m0_req && !g0_last && $urandom_range(0, 15) != 0))
                new_req(m0_req, m0_we, m0_addr, m0_wdata, m0_bsel, 60);
            if (!(m1_req && !g1_last && $urandom_range(0, 15) != 0))
                new_req(m1_req, m1_we, m1_addr, m1_wdata, m1_bsel, 55);
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 0;
        idle_flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
